// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic operand feeder and its array integration.
package systolic_pkg;

    localparam int FEED_PIPE_LAT = 2;

    localparam int MAC_NUM_DEF = 10;
    localparam int BW_ACT_DEF  = 8;
    localparam int BW_WET_DEF  = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_FETCH,
        ST_WAIT,
        ST_DRAIN
    } feeder_state_t;

    typedef logic signed [BW_ACT_DEF-1:0] act_vec_t [MAC_NUM_DEF];
    typedef logic signed [BW_WET_DEF-1:0] wet_vec_t [MAC_NUM_DEF];

endpackage

// File: rtl/systolic_operand_feeder_tile_counter.sv
// Tile index, last-tile flag, buffer address adders and drain down-counter for the feeder.
module feeder_tile_counter #(
    parameter int ADDR_W  = 10,
    parameter int LEN_W   = 8,
    parameter int DRAIN_W = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [ADDR_W-1:0]  act_base,
    input  logic [ADDR_W-1:0]  wet_base,
    input  logic [LEN_W-1:0]   len,
    input  logic               step,
    input  logic               drain_load,
    input  logic [DRAIN_W-1:0] drain_val,
    input  logic               drain_dec,
    output logic [ADDR_W-1:0]  act_addr,
    output logic [ADDR_W-1:0]  wet_addr,
    output logic               last,
    output logic               drain_zero
);

    logic [ADDR_W-1:0]  act_base_q;
    logic [ADDR_W-1:0]  wet_base_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   idx;
    logic [DRAIN_W-1:0] drain_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            act_base_q <= '0;
            wet_base_q <= '0;
            len_q      <= '0;
            idx        <= '0;
        end else if (load) begin
            act_base_q <= act_base;
            wet_base_q <= wet_base;
            len_q      <= len;
            idx        <= '0;
        end else if (step) begin
            idx <= idx + LEN_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            drain_cnt <= '0;
        end else if (drain_load) begin
            drain_cnt <= drain_val;
        end else if (drain_dec && (drain_cnt != '0)) begin
            drain_cnt <= drain_cnt - DRAIN_W'(1);
        end
    end

    // Address adders wrap naturally at 2^ADDR_W.
    assign act_addr   = act_base_q + ADDR_W'(idx);
    assign wet_addr   = wet_base_q + ADDR_W'(idx);
    assign last       = (idx == len_q - LEN_W'(1));
    assign drain_zero = (drain_cnt == '0);

endmodule

// File: rtl/systolic_operand_feeder.sv
// Command sequencer streaming operand tiles from the act/weight buffers into the 1xN MAC array.
//   state | meaning
//   IDLE  | ready for a command
//   CLEAR | clear accumulators, read tile 0
//   FETCH | read tiles 1..len-1
//   WAIT  | let the read pipeline empty
//   DRAIN | count down until the array result is valid, then pulse done
module systolic_operand_feeder
    import systolic_pkg::*;
#(
    parameter int MAC_NUM      = 10,
    parameter int BW_ACT       = 8,
    parameter int BW_WET       = 8,
    parameter int ADDR_W       = 10,
    parameter int LEN_W        = 8,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [ADDR_W-1:0]        cmd_act_base,
    input  logic [ADDR_W-1:0]        cmd_wet_base,
    input  logic [LEN_W-1:0]         cmd_len,
    input  logic [7:0]               cmd_shift,
    output logic                     buf_rd_en,
    output logic [ADDR_W-1:0]        buf_act_addr,
    output logic [ADDR_W-1:0]        buf_wet_addr,
    input  logic signed [BW_ACT-1:0] buf_act_data [MAC_NUM],
    input  logic signed [BW_WET-1:0] buf_wet_data [MAC_NUM],
    output logic                     PE_mac_enable,
    output logic                     PE_clear_acc,
    output logic signed [BW_ACT-1:0] PE_act_in [MAC_NUM],
    output logic signed [BW_WET-1:0] PE_wet_in [MAC_NUM],
    output logic [7:0]               PE_res_shift_num,
    output logic                     done
);

    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    feeder_state_t state, state_nxt;

    logic               accept;
    logic               drain_load;
    logic [DRAIN_W-1:0] drain_val;
    logic               last;
    logic               drain_zero;
    logic [FEED_PIPE_LAT-1:0] rd_pipe;

    feeder_tile_counter #(
        .ADDR_W  (ADDR_W),
        .LEN_W   (LEN_W),
        .DRAIN_W (DRAIN_W)
    ) u_tile_counter (
        .clk        (clk),
        .reset      (reset),
        .load       (accept),
        .act_base   (cmd_act_base),
        .wet_base   (cmd_wet_base),
        .len        (cmd_len),
        .step       (buf_rd_en),
        .drain_load (drain_load),
        .drain_val  (drain_val),
        .drain_dec  (state == ST_DRAIN),
        .act_addr   (buf_act_addr),
        .wet_addr   (buf_wet_addr),
        .last       (last),
        .drain_zero (drain_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        cmd_ready    = 1'b0;
        accept       = 1'b0;
        buf_rd_en    = 1'b0;
        PE_clear_acc = 1'b0;
        drain_load   = 1'b0;
        drain_val    = '0;
        done         = 1'b0;
        case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    accept = 1'b1;
                    if (cmd_len != '0) begin
                        state_nxt = ST_CLEAR;
                    end else begin
                        // One drain step keeps done two cycles after accept.
                        state_nxt  = ST_DRAIN;
                        drain_load = 1'b1;
                        drain_val  = DRAIN_W'(1);
                    end
                end
            end
            ST_CLEAR: begin
                PE_clear_acc = 1'b1;
                buf_rd_en    = 1'b1;
                state_nxt    = last ? ST_WAIT : ST_FETCH;
            end
            ST_FETCH: begin
                buf_rd_en = 1'b1;
                if (last) state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (!(|rd_pipe[FEED_PIPE_LAT-2:0])) begin
                    state_nxt  = ST_DRAIN;
                    drain_load = 1'b1;
                    drain_val  = DRAIN_W'(DRAIN_CYCLES - 1);
                end
            end
            ST_DRAIN: begin
                if (drain_zero) begin
                    done      = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_pipe          <= '0;
            PE_res_shift_num <= '0;
        end else begin
            rd_pipe <= {rd_pipe[FEED_PIPE_LAT-2:0], buf_rd_en};
            if (accept) PE_res_shift_num <= cmd_shift;
        end
    end

    // Buffer data arrives one cycle after the read strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MAC_NUM; i++) begin
                PE_act_in[i] <= '0;
                PE_wet_in[i] <= '0;
            end
        end else if (rd_pipe[0]) begin
            for (int i = 0; i < MAC_NUM; i++) begin
                PE_act_in[i] <= buf_act_data[i];
                PE_wet_in[i] <= buf_wet_data[i];
            end
        end
    end

    assign PE_mac_enable = rd_pipe[FEED_PIPE_LAT-1];

endmodule

// File: tb/tb_systolic_operand_feeder.sv
// Directed self-checking bench for systolic_operand_feeder with a behavioural buffer model.
module tb_systolic_operand_feeder;
    import systolic_pkg::*;

    localparam int MAC_NUM = 10;
    localparam int ADDR_W  = 10;
    localparam int LEN_W   = 8;
    localparam int DRAIN   = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [ADDR_W-1:0]  cmd_act_base;
    logic [ADDR_W-1:0]  cmd_wet_base;
    logic [LEN_W-1:0]   cmd_len;
    logic [7:0]         cmd_shift;
    logic               buf_rd_en;
    logic [ADDR_W-1:0]  buf_act_addr;
    logic [ADDR_W-1:0]  buf_wet_addr;
    act_vec_t           buf_act_data;
    wet_vec_t           buf_wet_data;
    logic               PE_mac_enable;
    logic               PE_clear_acc;
    act_vec_t           PE_act_in;
    wet_vec_t           PE_wet_in;
    logic [7:0]         PE_res_shift_num;
    logic               done;

    int errs   = 0;
    int checks = 0;
    int cur_k  = 0;

    systolic_operand_feeder #(
        .MAC_NUM(MAC_NUM), .BW_ACT(8), .BW_WET(8), .ADDR_W(ADDR_W),
        .LEN_W(LEN_W), .DRAIN_CYCLES(DRAIN)
    ) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_act_base(cmd_act_base), .cmd_wet_base(cmd_wet_base),
        .cmd_len(cmd_len), .cmd_shift(cmd_shift), .buf_rd_en(buf_rd_en),
        .buf_act_addr(buf_act_addr), .buf_wet_addr(buf_wet_addr),
        .buf_act_data(buf_act_data), .buf_wet_data(buf_wet_data),
        .PE_mac_enable(PE_mac_enable), .PE_clear_acc(PE_clear_acc),
        .PE_act_in(PE_act_in), .PE_wet_in(PE_wet_in),
        .PE_res_shift_num(PE_res_shift_num), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic signed [7:0] act_fn(logic [ADDR_W-1:0] a, int lane);
        return 8'(int'(a) * 3 + lane * 17);
    endfunction

    function automatic logic signed [7:0] wet_fn(logic [ADDR_W-1:0] a, int lane);
        return 8'(int'(a) * 5 + 100 - lane * 11);
    endfunction

    // Buffer model: data for the strobed address appears one cycle later.
    initial begin
        for (int i = 0; i < MAC_NUM; i++) begin
            buf_act_data[i] = '0;
            buf_wet_data[i] = '0;
        end
    end

    always @(posedge clk) begin
        if (buf_rd_en) begin
            for (int i = 0; i < MAC_NUM; i++) begin
                buf_act_data[i] <= act_fn(buf_act_addr, i);
                buf_wet_data[i] <= wet_fn(buf_wet_addr, i);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s at cycle offset %0d: got %0h expected %0h (t=%0t)", tag, cur_k, got, exp, $time);
        end
    endtask

    // Called at a negedge; the following posedge is the accept cycle T.
    task automatic run_cmd(input logic [ADDR_W-1:0] ab, input logic [ADDR_W-1:0] wb,
                           input logic [LEN_W-1:0] len, input logic [7:0] sh,
                           input bit nxt, input logic [ADDR_W-1:0] nab,
                           input logic [ADDR_W-1:0] nwb, input logic [LEN_W-1:0] nlen,
                           input logic [7:0] nsh);
        int done_k;
        logic [ADDR_W-1:0] ea, ew;
        cmd_valid    = 1'b1;
        cmd_act_base = ab;
        cmd_wet_base = wb;
        cmd_len      = len;
        cmd_shift    = sh;
        cur_k = 0;
        check("ready_at_accept", cmd_ready, 1'b1);
        done_k = (len != 0) ? int'(len) + 2 + DRAIN : 2;
        for (int k = 1; k <= done_k + 1; k++) begin
            @(negedge clk);
            cur_k = k;
            if (k == 1) begin
                if (nxt) begin
                    cmd_act_base = nab;
                    cmd_wet_base = nwb;
                    cmd_len      = nlen;
                    cmd_shift    = nsh;
                end else begin
                    cmd_valid = 1'b0;
                end
            end
            check("clear_acc", PE_clear_acc, (len != 0) && (k == 1));
            check("rd_en", buf_rd_en, (len != 0) && (k <= int'(len)));
            if ((len != 0) && (k <= int'(len))) begin
                ea = ab + ADDR_W'(k - 1);
                ew = wb + ADDR_W'(k - 1);
                check("act_addr", buf_act_addr, ea);
                check("wet_addr", buf_wet_addr, ew);
            end
            check("mac_enable", PE_mac_enable, (len != 0) && (k >= 3) && (k <= int'(len) + 2));
            if ((len != 0) && (k >= 3) && (k <= int'(len) + 2)) begin
                ea = ab + ADDR_W'(k - 3);
                ew = wb + ADDR_W'(k - 3);
                for (int i = 0; i < MAC_NUM; i++) begin
                    check("act_lane", PE_act_in[i], act_fn(ea, i));
                    check("wet_lane", PE_wet_in[i], wet_fn(ew, i));
                end
            end
            check("done", done, k == done_k);
            check("cmd_ready", cmd_ready, k == done_k + 1);
            check("shift_num", PE_res_shift_num, sh);
        end
    endtask

    initial begin
        reset        = 1'b1;
        cmd_valid    = 1'b0;
        cmd_act_base = '0;
        cmd_wet_base = '0;
        cmd_len      = '0;
        cmd_shift    = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", cmd_ready, 1'b1);
        check("rst_rd_en", buf_rd_en, 1'b0);
        check("rst_mac", PE_mac_enable, 1'b0);
        check("rst_clear", PE_clear_acc, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_act_addr", buf_act_addr, 10'h0);
        check("rst_wet_addr", buf_wet_addr, 10'h0);
        check("rst_shift", PE_res_shift_num, 8'h0);
        check("rst_act_in", PE_act_in[0], 8'h0);
        check("rst_wet_in", PE_wet_in[MAC_NUM-1], 8'h0);
        reset = 1'b0;
        @(negedge clk);

        run_cmd(10'h010, 10'h080, 8'd4, 8'd3, 1'b0, '0, '0, '0, '0);
        run_cmd(10'h020, 10'h040, 8'd1, 8'd5, 1'b0, '0, '0, '0, '0);
        run_cmd(10'h030, 10'h050, 8'd0, 8'd7, 1'b0, '0, '0, '0, '0);
        run_cmd(10'h3FE, 10'h3FF, 8'd4, 8'd1, 1'b0, '0, '0, '0, '0);

        // Back-to-back: valid stays high across the first command.
        run_cmd(10'h100, 10'h200, 8'd3, 8'd2, 1'b1, 10'h110, 10'h210, 8'd2, 8'd4);
        run_cmd(10'h110, 10'h210, 8'd2, 8'd4, 1'b0, '0, '0, '0, '0);

        // Reset in the middle of a len=8 command.
        cmd_valid    = 1'b1;
        cmd_act_base = 10'h050;
        cmd_wet_base = 10'h060;
        cmd_len      = 8'd8;
        cmd_shift    = 8'd9;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            cur_k = k;
            if (k == 1) begin
                cmd_valid = 1'b0;
                check("mid_clear", PE_clear_acc, 1'b1);
            end
            if (k == 4) reset = 1'b1;
        end
        for (int k = 5; k <= 10; k++) begin
            @(negedge clk);
            cur_k = k;
            if (k == 5) begin
                reset = 1'b0;
                check("post_rst_shift", PE_res_shift_num, 8'h0);
            end
            check("post_rst_mac", PE_mac_enable, 1'b0);
            check("post_rst_done", done, 1'b0);
            check("post_rst_rd_en", buf_rd_en, 1'b0);
            check("post_rst_ready", cmd_ready, 1'b1);
        end
        run_cmd(10'h005, 10'h006, 8'd2, 8'd6, 1'b0, '0, '0, '0, '0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
